alu_issue_ctrl: RTL



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_result_fifo.sv | 62 ++++++
 rtl/alu_issue_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared widths and opcode encodings for the registered ALU and its issue controller.
package alu_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INST_WIDTH  = 4;
    localparam int ENTRY_WIDTH = DATA_WIDTH + 1 + INST_WIDTH;

    localparam logic [INST_WIDTH-1:0] OP_ADD  = 4'd0;
    localparam logic [INST_WIDTH-1:0] OP_SUB  = 4'd1;
    localparam logic [INST_WIDTH-1:0] OP_MUL  = 4'd2;
    localparam logic [INST_WIDTH-1:0] OP_MAX  = 4'd3;
    localparam logic [INST_WIDTH-1:0] OP_MIN  = 4'd4;
    localparam logic [INST_WIDTH-1:0] OP_ADDU = 4'd5;
    localparam logic [INST_WIDTH-1:0] OP_SUBU = 4'd6;
    localparam logic [INST_WIDTH-1:0] OP_MULU = 4'd7;
    localparam logic [INST_WIDTH-1:0] OP_MAXU = 4'd8;
    localparam logic [INST_WIDTH-1:0] OP_MINU = 4'd9;
    localparam logic [INST_WIDTH-1:0] OP_AND  = 4'd10;
    localparam logic [INST_WIDTH-1:0] OP_OR   = 4'd11;
    localparam logic [INST_WIDTH-1:0] OP_XOR  = 4'd12;
    localparam logic [INST_WIDTH-1:0] OP_NOT  = 4'd13;
    localparam logic [INST_WIDTH-1:0] OP_REV  = 4'd14;

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous show-ahead FIFO holding tagged ALU results; head is visible while non-empty.
module alu_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != FULL_CNT) || do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues commands to the registered ALU and buffers its results with credit-based flow control.
import alu_pkg::*;

module alu_issue_ctrl #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int INST_WIDTH = alu_pkg::INST_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [DATA_WIDTH-1:0] i_cmd_a,
    input  logic [DATA_WIDTH-1:0] i_cmd_b,
    input  logic [INST_WIDTH-1:0] i_cmd_inst,
    output logic [DATA_WIDTH-1:0] o_alu_data_a,
    output logic [DATA_WIDTH-1:0] o_alu_data_b,
    output logic [INST_WIDTH-1:0] o_alu_inst,
    output logic                  o_alu_valid,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic                  i_alu_overflow,
    input  logic                  i_alu_valid,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [DATA_WIDTH-1:0] o_res_data,
    output logic                  o_res_overflow,
    output logic [INST_WIDTH-1:0] o_res_inst,
    output logic [CNT_WIDTH-1:0]  o_ovf_cnt,
    output logic                  o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + 1 + INST_WIDTH;

    logic [DATA_WIDTH-1:0] alu_a_reg;
    logic [DATA_WIDTH-1:0] alu_b_reg;
    logic [INST_WIDTH-1:0] alu_inst_reg;
    logic                  alu_valid_reg;
    logic                  expect_reg;
    logic [INST_WIDTH-1:0] inst_d1_reg;
    logic [CNT_WIDTH-1:0]  ovf_cnt_reg;
    logic                  err_reg;

    logic                  accept;
    logic                  capture;
    logic                  fifo_empty;
    logic [AW:0]           fifo_count;
    logic [EW-1:0]         fifo_head;
    logic [AW+1:0]         committed;

    // Every issued command owns a FIFO slot from acceptance until its result is popped.
    assign committed   = (AW+2)'(fifo_count) + (AW+2)'(alu_valid_reg) + (AW+2)'(expect_reg);
    assign o_cmd_ready = (committed < (AW+2)'(DEPTH));
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign capture     = expect_reg && i_alu_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_inst_reg  <= '0;
            alu_valid_reg <= 1'b0;
            expect_reg    <= 1'b0;
            inst_d1_reg   <= '0;
            ovf_cnt_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            alu_valid_reg <= accept;
            if (accept) begin
                alu_a_reg    <= i_cmd_a;
                alu_b_reg    <= i_cmd_b;
                alu_inst_reg <= i_cmd_inst;
            end
            expect_reg  <= alu_valid_reg;
            inst_d1_reg <= alu_inst_reg;
            if (capture && i_alu_overflow && (ovf_cnt_reg != '1)) begin
                ovf_cnt_reg <= ovf_cnt_reg + CNT_WIDTH'(1);
            end
            if (i_alu_valid != expect_reg) begin
                err_reg <= 1'b1;
            end
        end
    end

    alu_result_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (capture),
        .push_data ({i_alu_data, i_alu_overflow, inst_d1_reg}),
        .pop       (i_res_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_alu_data_a   = alu_a_reg;
    assign o_alu_data_b   = alu_b_reg;
    assign o_alu_inst     = alu_inst_reg;
    assign o_alu_valid    = alu_valid_reg;
    assign o_res_valid    = !fifo_empty;
    assign o_res_data     = fifo_head[EW-1 -: DATA_WIDTH];
    assign o_res_overflow = fifo_head[INST_WIDTH];
    assign o_res_inst     = fifo_head[INST_WIDTH-1:0];
    assign o_ovf_cnt      = ovf_cnt_reg;
    assign o_err          = err_reg;

endmodule
